riscv_insn_cov_monitor: RTL and testbench

//  Retirement-side ISA coverage monitor for RV32I/RV64I with optional C.
//  Per cycle it classifies up to NRET retired instructions (SYSTEM excluded) as legal/illegal.
//  It accumulates sticky per-class hit bins and saturating counts, and captures the first illegal word.
//  It sits on the RVFI bus beside the checkers and feeds coverage cover()/assert() properties.

---
 rtl/riscv_cov_pkg.sv | 74 +++++++
 rtl/riscv_insn_classify.sv | 169 ++++++++++++++++
 rtl/riscv_insn_cov_monitor.sv | 127 ++++++++++++
 tb/tb_riscv_insn_cov_monitor.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_cov_pkg.sv
// riscv_cov_pkg
//   Shared definitions for the retirement-side ISA coverage monitor:
//   coverage class codes (bin indices), opcode/funct constants and the
//   XLEN-dependent mask of bins that can never be hit and therefore
//   start out set.
//   Configuration macro: RISCV_COV_RVC_EN (compressed decode enabled).
package riscv_cov_pkg;

    localparam int unsigned NBINS = 16;

    // Coverage class codes, also the bit index into cov_bins
    localparam logic [3:0] CLS_LUI     = 4'd0;
    localparam logic [3:0] CLS_AUIPC   = 4'd1;
    localparam logic [3:0] CLS_JAL     = 4'd2;
    localparam logic [3:0] CLS_JALR    = 4'd3;
    localparam logic [3:0] CLS_BRANCH  = 4'd4;
    localparam logic [3:0] CLS_LOAD    = 4'd5;
    localparam logic [3:0] CLS_STORE   = 4'd6;
    localparam logic [3:0] CLS_OPIMM   = 4'd7;
    localparam logic [3:0] CLS_OP      = 4'd8;
    localparam logic [3:0] CLS_OPIMM32 = 4'd9;
    localparam logic [3:0] CLS_OP32    = 4'd10;
    localparam logic [3:0] CLS_CQ0     = 4'd11;
    localparam logic [3:0] CLS_CQ1     = 4'd12;
    localparam logic [3:0] CLS_CQ2     = 4'd13;
    localparam logic [3:0] CLS_RSVD14  = 4'd14;
    localparam logic [3:0] CLS_RSVD15  = 4'd15;

    // Major opcodes (full 7 bits, so [1:0]==2'b11 is implied)
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;

    // funct3 / funct7 values used by the shift and add/sub checks
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;
    localparam logic [6:0] F7_STD = 7'b0000000;
    localparam logic [6:0] F7_ALT = 7'b0100000;

`ifdef RISCV_COV_RVC_EN
    localparam bit RVC_EN = 1'b1;
`else
    localparam bit RVC_EN = 1'b0;
`endif

    // Bins that no legal instruction can reach in this build; they are
    // pre-set so that all_covered only depends on reachable classes.
    function automatic logic [NBINS-1:0] inapplicable_mask(input int unsigned xlen);
        logic [NBINS-1:0] m;
        m = '0;
        m[CLS_RSVD14] = 1'b1;
        m[CLS_RSVD15] = 1'b1;
        if (xlen != 64) begin
            m[CLS_OPIMM32] = 1'b1;
            m[CLS_OP32]    = 1'b1;
        end
        if (!RVC_EN) begin
            m[CLS_CQ0] = 1'b1;
            m[CLS_CQ1] = 1'b1;
            m[CLS_CQ2] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/riscv_insn_classify.sv
// riscv_insn_classify
//   Purely combinational legality check and class decode of one retired
//   instruction word for RV32I/RV64I, optionally with the C extension.
//   SYSTEM and every unlisted opcode decode as illegal.
//   Configuration macro: RISCV_COV_RVC_EN (compressed decode enabled).
// Ports
//   insn   in   32  instruction word (RVC in [15:0] with [31:16]==0)
//   legal  out  1   word is a legal, non-SYSTEM instruction
//   cls    out  4   class code (meaningful only when legal)
module riscv_insn_classify
    import riscv_cov_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0] insn,
    output logic        legal,
    output logic [3:0]  cls
);

    localparam bit IS_RV64 = (XLEN == 64);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       f7_std_alt;
    logic       shl_ok;
    logic       shr_ok;
    logic       rvc_ok;
    logic       unused_insn_bits;

    assign opc        = insn[6:0];
    assign f3         = insn[14:12];
    assign f7         = insn[31:25];
    assign f7_std_alt = (f7 == F7_STD) || (f7 == F7_ALT);

    // RV64 widens shamt to 6 bits, so only insn[31:26] carries the funct
    assign shl_ok = IS_RV64 ? (insn[31:26] == 6'b000000) : (f7 == F7_STD);
    assign shr_ok = IS_RV64 ? ((insn[31:26] == 6'b000000) || (insn[31:26] == 6'b010000))
                            : f7_std_alt;

    // Register/immediate fields only matter to the compressed decoder
    assign unused_insn_bits = ^insn;

`ifdef RISCV_COV_RVC_EN
    logic [2:0] cf3;
    logic [4:0] crd;
    logic [4:0] crs2;

    assign cf3  = insn[15:13];
    assign crd  = insn[11:7];
    assign crs2 = insn[6:2];

    always_comb begin
        rvc_ok = 1'b0;
        case (insn[1:0])
            2'b00: begin
                case (cf3)
                    3'b000:         rvc_ok = (insn[12:5] != 8'd0);   // C.ADDI4SPN
                    3'b010, 3'b110: rvc_ok = 1'b1;                   // C.LW / C.SW
                    3'b011, 3'b111: rvc_ok = IS_RV64;                // C.LD / C.SD
                    default:        rvc_ok = 1'b0;
                endcase
            end
            2'b01: begin
                case (cf3)
                    3'b000, 3'b010, 3'b101, 3'b110, 3'b111: rvc_ok = 1'b1;
                    3'b001: rvc_ok = IS_RV64 ? (crd != 5'd0) : 1'b1; // C.ADDIW / C.JAL
                    // C.ADDI16SP and C.LUI both keep their immediate in {[12],[6:2]}
                    3'b011: rvc_ok = ({insn[12], insn[6:2]} != 6'd0);
                    3'b100: begin
                        case (insn[11:10])
                            2'b00, 2'b01: rvc_ok = IS_RV64 || !insn[12];  // C.SRLI/C.SRAI
                            2'b10:        rvc_ok = 1'b1;                  // C.ANDI
                            default:      rvc_ok = !insn[12] || (IS_RV64 && !insn[6]);
                        endcase
                    end
                    default: rvc_ok = 1'b0;
                endcase
            end
            2'b10: begin
                case (cf3)
                    3'b000: rvc_ok = IS_RV64 || !insn[12];           // C.SLLI
                    3'b010: rvc_ok = (crd != 5'd0);                  // C.LWSP
                    3'b011: rvc_ok = IS_RV64 && (crd != 5'd0);       // C.LDSP
                    // JR/MV/JALR/ADD collapse to this; only rd=rs2=0 fails
                    // (reserved C.JR, or C.EBREAK)
                    3'b100: rvc_ok = (crs2 != 5'd0) || (crd != 5'd0);
                    3'b110: rvc_ok = 1'b1;                           // C.SWSP
                    3'b111: rvc_ok = IS_RV64;                        // C.SDSP
                    default: rvc_ok = 1'b0;
                endcase
            end
            default: rvc_ok = 1'b0;
        endcase
    end
`else
    assign rvc_ok = 1'b0;
`endif

    always_comb begin
        legal = 1'b0;
        cls   = CLS_RSVD15;
        if (insn[1:0] == 2'b11) begin
            case (opc)
                OPC_LUI:    begin cls = CLS_LUI;    legal = 1'b1; end
                OPC_AUIPC:  begin cls = CLS_AUIPC;  legal = 1'b1; end
                OPC_JAL:    begin cls = CLS_JAL;    legal = 1'b1; end
                OPC_JALR:   begin cls = CLS_JALR;   legal = (f3 == 3'b000); end
                OPC_BRANCH: begin
                    cls   = CLS_BRANCH;
                    legal = (f3 != 3'b010) && (f3 != 3'b011);
                end
                OPC_LOAD: begin
                    cls = CLS_LOAD;
                    case (f3)
                        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                        3'b011, 3'b110:                         legal = IS_RV64;
                        default:                                legal = 1'b0;
                    endcase
                end
                OPC_STORE: begin
                    cls   = CLS_STORE;
                    legal = (f3 <= 3'b010) || (IS_RV64 && (f3 == 3'b011));
                end
                OPC_OPIMM: begin
                    cls = CLS_OPIMM;
                    case (f3)
                        F3_SLL:  legal = shl_ok;
                        F3_SRX:  legal = shr_ok;
                        default: legal = 1'b1;
                    endcase
                end
                OPC_OP: begin
                    cls = CLS_OP;
                    case (f3)
                        F3_ADD, F3_SRX: legal = f7_std_alt;
                        default:        legal = (f7 == F7_STD);
                    endcase
                end
                OPC_OPIMM32: begin
                    cls = CLS_OPIMM32;
                    case (f3)
                        F3_ADD:  legal = IS_RV64;
                        F3_SLL:  legal = IS_RV64 && (f7 == F7_STD);
                        F3_SRX:  legal = IS_RV64 && f7_std_alt;
                        default: legal = 1'b0;
                    endcase
                end
                OPC_OP32: begin
                    cls = CLS_OP32;
                    case (f3)
                        F3_ADD, F3_SRX: legal = IS_RV64 && f7_std_alt;
                        F3_SLL:         legal = IS_RV64 && (f7 == F7_STD);
                        default:        legal = 1'b0;
                    endcase
                end
                default: legal = 1'b0;
            endcase
        end else begin
            legal = rvc_ok && (insn[31:16] == 16'd0);
            case (insn[1:0])
                2'b00:   cls = CLS_CQ0;
                2'b01:   cls = CLS_CQ1;
                default: cls = CLS_CQ2;
            endcase
        end
    end

endmodule

// File: rtl/riscv_insn_cov_monitor.sv
// riscv_insn_cov_monitor
//   Retirement-side ISA coverage monitor on the RVFI bus. Classifies up to
//   NRET retirements per cycle, keeps sticky class-hit bins, saturating
//   legal/illegal counts and the first illegal word with its channel.
//   Outputs reflect a cycle's retirements after the following clock edge.
//   Configuration macro: RISCV_COV_RVC_EN (compressed decode enabled).
// Parameters
//   XLEN   32 or 64
//   NRET   retire channels 1..4, channel 0 oldest
//   CNT_W  width of the two counters
// Ports
//   clock        in   1        clock
//   reset        in   1        synchronous active-high reset
//   clear        in   1        synchronous statistics clear (drops that cycle)
//   rvfi_valid   in   NRET     per-channel retire strobe
//   rvfi_insn    in   32*NRET  channel n in [32n+31:32n]
//   cov_bins     out  16       sticky class-hit bitmap
//   all_covered  out  1        every bin set
//   insn_count   out  CNT_W    legal retirements, saturating
//   bad_count    out  CNT_W    illegal retirements, saturating
//   bad_seen     out  1        sticky illegal flag
//   bad_insn     out  32       first illegal word
//   bad_chan     out  2        channel of bad_insn
module riscv_insn_cov_monitor
    import riscv_cov_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NRET  = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic [NRET-1:0]     rvfi_valid,
    input  logic [32*NRET-1:0]  rvfi_insn,
    output logic [NBINS-1:0]    cov_bins,
    output logic                all_covered,
    output logic [CNT_W-1:0]    insn_count,
    output logic [CNT_W-1:0]    bad_count,
    output logic                bad_seen,
    output logic [31:0]         bad_insn,
    output logic [1:0]          bad_chan
);

    localparam logic [NBINS-1:0] INAPP_MASK = inapplicable_mask(XLEN);

    logic [NRET-1:0]  ch_legal;
    logic [3:0]       ch_cls [NRET];
    logic [NRET-1:0]  good_vec;
    logic [NRET-1:0]  bad_vec;
    logic [NBINS-1:0] hit;
    logic [2:0]       good_pop;
    logic [2:0]       bad_pop;
    logic [31:0]      pick_insn;
    logic [1:0]       pick_chan;
    logic             pick_found;

    for (genvar g = 0; g < NRET; g++) begin : g_cls
        riscv_insn_classify #(
            .XLEN (XLEN)
        ) u_classify (
            .insn  (rvfi_insn[32*g +: 32]),
            .legal (ch_legal[g]),
            .cls   (ch_cls[g])
        );
    end

    assign good_vec = rvfi_valid & ch_legal;
    assign bad_vec  = rvfi_valid & ~ch_legal;

    // Per-cycle hit vector, popcounts and lowest-index illegal pick
    always_comb begin
        hit        = '0;
        good_pop   = '0;
        bad_pop    = '0;
        pick_insn  = '0;
        pick_chan  = '0;
        pick_found = 1'b0;
        for (int unsigned i = 0; i < NRET; i++) begin
            if (good_vec[i]) begin
                hit[ch_cls[i]] = 1'b1;
                good_pop       = good_pop + 3'd1;
            end
            if (bad_vec[i]) begin
                bad_pop = bad_pop + 3'd1;
                if (!pick_found) begin
                    pick_found = 1'b1;
                    pick_insn  = rvfi_insn[32*i +: 32];
                    pick_chan  = 2'(i);
                end
            end
        end
    end

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [2:0]       b);
        logic [CNT_W+2:0] s;
        s = {3'b000, a} + {{CNT_W{1'b0}}, b};
        if (s[CNT_W+2:CNT_W] != 3'b000) begin
            return '1;
        end
        return s[CNT_W-1:0];
    endfunction

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cov_bins   <= INAPP_MASK;
            insn_count <= '0;
            bad_count  <= '0;
            bad_seen   <= 1'b0;
            bad_insn   <= '0;
            bad_chan   <= '0;
        end else begin
            cov_bins   <= cov_bins | hit;
            insn_count <= sat_add(insn_count, good_pop);
            bad_count  <= sat_add(bad_count, bad_pop);
            if (!bad_seen && pick_found) begin
                bad_seen <= 1'b1;
                bad_insn <= pick_insn;
                bad_chan <= pick_chan;
            end
        end
    end

    assign all_covered = &cov_bins;

endmodule

// File: tb/tb_riscv_insn_cov_monitor.sv
module tb_riscv_insn_cov_monitor;

`ifdef RISCV_COV_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [2:0]  sv    = '0;
    logic [31:0] sw0 = '0, sw1 = '0, sw2 = '0;

    // Instance A: XLEN=32, two channels, 4-bit counters
    logic [15:0] a_cov;  logic a_all; logic [3:0] a_ic, a_bc;
    logic a_seen; logic [31:0] a_bi; logic [1:0] a_bch;
    riscv_insn_cov_monitor #(.XLEN(32), .NRET(2), .CNT_W(4)) dut_a (
        .clock(clock), .reset(reset), .clear(clear),
        .rvfi_valid(sv[1:0]), .rvfi_insn({sw1, sw0}),
        .cov_bins(a_cov), .all_covered(a_all), .insn_count(a_ic), .bad_count(a_bc),
        .bad_seen(a_seen), .bad_insn(a_bi), .bad_chan(a_bch));

    // Instance B: XLEN=64, three channels, 8-bit counters
    logic [15:0] b_cov;  logic b_all; logic [7:0] b_ic, b_bc;
    logic b_seen; logic [31:0] b_bi; logic [1:0] b_bch;
    riscv_insn_cov_monitor #(.XLEN(64), .NRET(3), .CNT_W(8)) dut_b (
        .clock(clock), .reset(reset), .clear(clear),
        .rvfi_valid(sv), .rvfi_insn({sw2, sw1, sw0}),
        .cov_bins(b_cov), .all_covered(b_all), .insn_count(b_ic), .bad_count(b_bc),
        .bad_seen(b_seen), .bad_insn(b_bi), .bad_chan(b_bch));

    int errors = 0;
    int checks = 0;

    // ---------------- reference model: ISA encoding table ----------------
    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        logic [31:0] nz;     // if nonzero, (w & nz) must be nonzero
        logic [3:0]  cls;
        int          xl;     // 0 = both, else only this XLEN
    } pat_t;
    pat_t pats[$];

    function automatic void add(logic [31:0] mask, logic [31:0] match, logic [31:0] nz,
                                logic [3:0] cls, int xl);
        pat_t p;
        p.mask = mask; p.match = match; p.nz = nz; p.cls = cls; p.xl = xl;
        pats.push_back(p);
    endfunction

    // Compressed encodings: upper half must be zero
    function automatic void addc(logic [15:0] mask, logic [15:0] match, logic [15:0] nz,
                                 logic [3:0] cls, int xl);
        add({16'hFFFF, mask}, {16'h0, match}, {16'h0, nz}, cls, xl);
    endfunction

    function automatic void build_table();
        add(32'h7F, 32'h37, 0, 0, 0);
        add(32'h7F, 32'h17, 0, 1, 0);
        add(32'h7F, 32'h6F, 0, 2, 0);
        add(32'h707F, 32'h67, 0, 3, 0);
        foreach (pats[i]) ; // keeps table order explicit
        add(32'h707F, 32'h0063, 0, 4, 0); add(32'h707F, 32'h1063, 0, 4, 0);
        add(32'h707F, 32'h4063, 0, 4, 0); add(32'h707F, 32'h5063, 0, 4, 0);
        add(32'h707F, 32'h6063, 0, 4, 0); add(32'h707F, 32'h7063, 0, 4, 0);
        add(32'h707F, 32'h0003, 0, 5, 0); add(32'h707F, 32'h1003, 0, 5, 0);
        add(32'h707F, 32'h2003, 0, 5, 0); add(32'h707F, 32'h4003, 0, 5, 0);
        add(32'h707F, 32'h5003, 0, 5, 0);
        add(32'h707F, 32'h3003, 0, 5, 64); add(32'h707F, 32'h6003, 0, 5, 64);
        add(32'h707F, 32'h0023, 0, 6, 0); add(32'h707F, 32'h1023, 0, 6, 0);
        add(32'h707F, 32'h2023, 0, 6, 0); add(32'h707F, 32'h3023, 0, 6, 64);
        add(32'h707F, 32'h0013, 0, 7, 0); add(32'h707F, 32'h2013, 0, 7, 0);
        add(32'h707F, 32'h3013, 0, 7, 0); add(32'h707F, 32'h4013, 0, 7, 0);
        add(32'h707F, 32'h6013, 0, 7, 0); add(32'h707F, 32'h7013, 0, 7, 0);
        add(32'hFE00707F, 32'h1013, 0, 7, 32); add(32'hFE00707F, 32'h5013, 0, 7, 32);
        add(32'hFE00707F, 32'h40005013, 0, 7, 32);
        add(32'hFC00707F, 32'h1013, 0, 7, 64); add(32'hFC00707F, 32'h5013, 0, 7, 64);
        add(32'hFC00707F, 32'h40005013, 0, 7, 64);
        add(32'hFE00707F, 32'h0033, 0, 8, 0); add(32'hFE00707F, 32'h40000033, 0, 8, 0);
        add(32'hFE00707F, 32'h1033, 0, 8, 0); add(32'hFE00707F, 32'h2033, 0, 8, 0);
        add(32'hFE00707F, 32'h3033, 0, 8, 0); add(32'hFE00707F, 32'h4033, 0, 8, 0);
        add(32'hFE00707F, 32'h5033, 0, 8, 0); add(32'hFE00707F, 32'h40005033, 0, 8, 0);
        add(32'hFE00707F, 32'h6033, 0, 8, 0); add(32'hFE00707F, 32'h7033, 0, 8, 0);
        add(32'h707F, 32'h001B, 0, 9, 64);
        add(32'hFE00707F, 32'h101B, 0, 9, 64); add(32'hFE00707F, 32'h501B, 0, 9, 64);
        add(32'hFE00707F, 32'h4000501B, 0, 9, 64);
        add(32'hFE00707F, 32'h003B, 0, 10, 64); add(32'hFE00707F, 32'h4000003B, 0, 10, 64);
        add(32'hFE00707F, 32'h103B, 0, 10, 64); add(32'hFE00707F, 32'h503B, 0, 10, 64);
        add(32'hFE00707F, 32'h4000503B, 0, 10, 64);
        if (RVC) begin
            addc(16'hE003, 16'h0000, 16'h1FE0, 11, 0);  // C.ADDI4SPN
            addc(16'hE003, 16'h4000, 0, 11, 0);         // C.LW
            addc(16'hE003, 16'hC000, 0, 11, 0);         // C.SW
            addc(16'hE003, 16'h6000, 0, 11, 64);        // C.LD
            addc(16'hE003, 16'hE000, 0, 11, 64);        // C.SD
            addc(16'hE003, 16'h0001, 0, 12, 0);         // C.ADDI / C.NOP
            addc(16'hE003, 16'h2001, 0, 12, 32);        // C.JAL
            addc(16'hE003, 16'h2001, 16'h0F80, 12, 64); // C.ADDIW
            addc(16'hE003, 16'h4001, 0, 12, 0);         // C.LI
            addc(16'hEF83, 16'h6101, 16'h107C, 12, 0);  // C.ADDI16SP
            addc(16'hE003, 16'h6001, 16'h107C, 12, 0);  // C.LUI
            addc(16'hFC03, 16'h8001, 0, 12, 32);        // C.SRLI
            addc(16'hFC03, 16'h8401, 0, 12, 32);        // C.SRAI
            addc(16'hEC03, 16'h8001, 0, 12, 64);
            addc(16'hEC03, 16'h8401, 0, 12, 64);
            addc(16'hEC03, 16'h8801, 0, 12, 0);         // C.ANDI
            addc(16'hFC63, 16'h8C01, 0, 12, 0); addc(16'hFC63, 16'h8C21, 0, 12, 0);
            addc(16'hFC63, 16'h8C41, 0, 12, 0); addc(16'hFC63, 16'h8C61, 0, 12, 0);
            addc(16'hFC63, 16'h9C01, 0, 12, 64); addc(16'hFC63, 16'h9C21, 0, 12, 64);
            addc(16'hE003, 16'hA001, 0, 12, 0);         // C.J
            addc(16'hE003, 16'hC001, 0, 12, 0);         // C.BEQZ
            addc(16'hE003, 16'hE001, 0, 12, 0);         // C.BNEZ
            addc(16'hF003, 16'h0002, 0, 13, 32);        // C.SLLI
            addc(16'hE003, 16'h0002, 0, 13, 64);
            addc(16'hE003, 16'h4002, 16'h0F80, 13, 0);  // C.LWSP
            addc(16'hE003, 16'h6002, 16'h0F80, 13, 64); // C.LDSP
            addc(16'hF07F, 16'h8002, 16'h0F80, 13, 0);  // C.JR
            addc(16'hF003, 16'h8002, 16'h007C, 13, 0);  // C.MV
            addc(16'hF07F, 16'h9002, 16'h0F80, 13, 0);  // C.JALR
            addc(16'hF003, 16'h9002, 16'h007C, 13, 0);  // C.ADD
            addc(16'hE003, 16'hC002, 0, 13, 0);         // C.SWSP
            addc(16'hE003, 16'hE002, 0, 13, 64);        // C.SDSP
        end
    endfunction

    function automatic void ref_classify(input int xl, input logic [31:0] w,
                                         output bit legal, output int cls);
        legal = 0; cls = 0;
        foreach (pats[i]) begin
            if (pats[i].xl != 0 && pats[i].xl != xl) continue;
            if ((w & pats[i].mask) != pats[i].match) continue;
            if (pats[i].nz != 0 && (w & pats[i].nz) == 0) continue;
            legal = 1; cls = int'(pats[i].cls);
            return;
        end
    endfunction

    // ---------------- model state and scoreboard ----------------
    typedef struct packed {
        logic [15:0] cov;
        logic [7:0]  ic;
        logic [7:0]  bc;
        logic        seen;
        logic [31:0] bi;
        logic [1:0]  bch;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    logic [15:0] m_cov [2];
    int          m_ic  [2];
    int          m_bc  [2];
    bit          m_seen[2];
    logic [31:0] m_bi  [2];
    int          m_bch [2];

    function automatic logic [15:0] unreachable_bins(int xl);
        logic [15:0] m = 16'hC000;
        if (xl == 32) m |= 16'h0600;
        if (!RVC)     m |= 16'h3800;
        return m;
    endfunction

    function automatic void model_step(int d);
        int xl   = (d == 0) ? 32 : 64;
        int nret = (d == 0) ? 2 : 3;
        int cmax = (d == 0) ? 15 : 255;
        logic [31:0] w;
        bit lg; int c;
        if (reset || clear) begin
            m_cov[d] = unreachable_bins(xl);
            m_ic[d] = 0; m_bc[d] = 0; m_seen[d] = 0; m_bi[d] = 0; m_bch[d] = 0;
            return;
        end
        for (int ch = 0; ch < nret; ch++) begin
            if (!sv[ch]) continue;
            w = (ch == 0) ? sw0 : (ch == 1) ? sw1 : sw2;
            ref_classify(xl, w, lg, c);
            if (lg) begin
                if (m_ic[d] < cmax) m_ic[d]++;
                m_cov[d][c] = 1'b1;
            end else begin
                if (m_bc[d] < cmax) m_bc[d]++;
                if (!m_seen[d]) begin
                    m_seen[d] = 1; m_bi[d] = w; m_bch[d] = ch;
                end
            end
        end
    endfunction

    function automatic exp_t snap(int d);
        exp_t e;
        e.cov = m_cov[d]; e.ic = 8'(m_ic[d]); e.bc = 8'(m_bc[d]);
        e.seen = m_seen[d]; e.bi = m_bi[d]; e.bch = 2'(m_bch[d]);
        return e;
    endfunction

    task automatic drive(bit rst, bit clr, logic [2:0] v,
                         logic [31:0] w0, logic [31:0] w1, logic [31:0] w2);
        @(negedge clock);
        reset = rst; clear = clr; sv = v; sw0 = w0; sw1 = w1; sw2 = w2;
        model_step(0);
        model_step(1);
        qa.push_back(snap(0));
        qb.push_back(snap(1));
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares each settled output set against the queued prediction
    initial begin
        exp_t ea, eb;
        forever begin
            @(posedge clock);
            #1;
            if (qa.size() > 0 && qb.size() > 0) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                chk("A.cov_bins",    32'(a_cov),  32'(ea.cov));
                chk("A.all_covered", 32'(a_all),  32'(&ea.cov));
                chk("A.insn_count",  32'(a_ic),   32'(ea.ic));
                chk("A.bad_count",   32'(a_bc),   32'(ea.bc));
                chk("A.bad_seen",    32'(a_seen), 32'(ea.seen));
                chk("A.bad_insn",    a_bi,        ea.bi);
                chk("A.bad_chan",    32'(a_bch),  32'(ea.bch));
                chk("B.cov_bins",    32'(b_cov),  32'(eb.cov));
                chk("B.all_covered", 32'(b_all),  32'(&eb.cov));
                chk("B.insn_count",  32'(b_ic),   32'(eb.ic));
                chk("B.bad_count",   32'(b_bc),   32'(eb.bc));
                chk("B.bad_seen",    32'(b_seen), 32'(eb.seen));
                chk("B.bad_insn",    b_bi,        eb.bi);
                chk("B.bad_chan",    32'(b_bch),  32'(eb.bch));
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] rand_insn();
        logic [31:0] w = $urandom;
        int unsigned r = $urandom_range(0, 9);
        if (r <= 5) begin
            case ($urandom_range(0, 12))
                0: w[6:0] = 7'h37;  1: w[6:0] = 7'h17;  2: w[6:0] = 7'h6F;
                3: w[6:0] = 7'h67;  4: w[6:0] = 7'h63;  5: w[6:0] = 7'h03;
                6: w[6:0] = 7'h23;  7: w[6:0] = 7'h13;  8: w[6:0] = 7'h33;
                9: w[6:0] = 7'h1B; 10: w[6:0] = 7'h3B; 11: w[6:0] = 7'h73;
                default: w[6:0] = 7'h0F;
            endcase
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:26] = 6'h00;
                default: ;
            endcase
        end else if (r <= 7) begin
            w[31:16] = '0;
            w[1:0]   = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) w[11:7] = '0;
            if ($urandom_range(0, 3) == 0) w[6:2]  = '0;
            if ($urandom_range(0, 2) == 0) w[12]   = 1'b0;
        end else if (r == 9) begin
            case ($urandom_range(0, 6))
                0: w = 32'h00000013; 1: w = 32'h00000073; 2: w = 32'h0000003B;
                3: w = 32'h0000303B; 4: w = 32'h00003003; 5: w = 32'h00009002;
                default: w = 32'h00000001;
            endcase
        end
        return w;
    endfunction

    initial begin
        build_table();
        repeat (3) drive(1, 0, 3'b000, 0, 0, 0);
        drive(0, 0, 3'b000, 0, 0, 0);                         // reset values, no traffic
        drive(0, 0, 3'b001, 32'h00000013, 0, 0);              // ADDI
        drive(0, 0, 3'b011, 32'h00000073, 32'h0000003B, 0);   // ECALL + ADDW
        drive(0, 0, 3'b000, 0, 0, 0);
        drive(1, 0, 3'b000, 0, 0, 0);
        drive(0, 0, 3'b001, 32'h0000303B, 0, 0);              // OP-32 f3=011
        drive(0, 0, 3'b001, 32'h00003003, 0, 0);              // LD
        drive(0, 0, 3'b001, 32'h00009002, 0, 0);              // C.EBREAK
        drive(0, 0, 3'b001, 32'h00000001, 0, 0);              // C.NOP
        drive(0, 0, 3'b110, 32'hFFFFFFFF, 32'h00000073, 32'h00000063); // bad on ch1
        drive(0, 1, 3'b000, 0, 0, 0);
        repeat (20) drive(0, 0, 3'b001, 32'h00000013, 0, 0);  // saturate A at 15
        drive(0, 1, 3'b111, 32'h00000013, 32'h00000073, 32'h00000013); // clear wins
        drive(0, 0, 3'b000, 0, 0, 0);
        for (int i = 0; i < 500; i++) begin
            drive(0, ($urandom_range(0, 79) == 0), 3'($urandom),
                  rand_insn(), rand_insn(), rand_insn());
        end
        drive(0, 0, 3'b000, 0, 0, 0);
        for (int i = 0; i < 20 && qa.size() > 0; i++) @(posedge clock);
        #2;
        if (qa.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d predictions left unchecked, required 0", qa.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
